// File: rtl/scanline_pkg.sv
// Shared types and helpers for the triple-buffered scanline store.
package scanline_pkg;

  localparam int NUM_BANKS     = 3;
  localparam int BLANK_DEFAULT = 0;

  typedef logic [1:0] bank_t;

  // The remaining bank of {0,1,2} given two distinct ones.
  function automatic bank_t third_bank(input bank_t a, input bank_t b);
    return bank_t'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// One scanline of pixel storage: synchronous write, asynchronous read.
// Built from flops so it maps onto plain standard cells.
module line_bank_ram #(
  parameter int DATA_W      = 7,
  parameter int LINE_PIXELS = 160,
  parameter int AW          = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LINE_PIXELS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/scanline_triple_buffer.sv
// Three rotating line banks (write / ready / display) between a slow pixel producer
// and the VGA scan-out; display bank only switches at a VGA line start.
module scanline_triple_buffer
  import scanline_pkg::*;
#(
  parameter int                DATA_W      = 7,
  parameter int                LINE_PIXELS = 160,
  parameter int                XW          = 10,
  parameter int                HSCALE      = 4,
  parameter logic [DATA_W-1:0] BLANK       = DATA_W'(BLANK_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_xpos,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_line_done,
  input  logic [XW-1:0]     rd_hpos,
  input  logic              rd_display_on,
  output logic [DATA_W-1:0] rd_data,
  output logic              line_missed
);

  localparam int SHIFT = $clog2(HSCALE);
  localparam int AW    = 8;

  bank_t wr_bank, ready_bank, rd_bank;
  bank_t wr_bank_n, ready_bank_n, rd_bank_n;
  logic  ready_valid, rd_valid, fresh;
  logic  ready_valid_n, rd_valid_n, fresh_n;

  logic              line_start;
  logic              swap;
  logic              wr_in_range;
  logic [XW-1:0]     sx;
  logic              sx_in_range;
  logic [NUM_BANKS-1:0] bank_we;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0] pix;
  logic [DATA_W-1:0] rd_data_n;

  assign line_start  = (rd_hpos == '0);
  // A line start only moves the display to a newer line; otherwise the current
  // line repeats, which is how vertical doubling falls out.
  assign swap        = line_start && (fresh || wr_line_done);
  assign wr_in_range = 32'(wr_xpos) < LINE_PIXELS;
  assign sx          = rd_hpos >> SHIFT;
  assign sx_in_range = 32'(sx) < LINE_PIXELS;

  always_comb begin
    wr_bank_n     = wr_bank;
    ready_bank_n  = ready_bank;
    rd_bank_n     = rd_bank;
    ready_valid_n = ready_valid | wr_line_done;
    fresh_n       = fresh;

    if (wr_line_done) begin
      ready_bank_n = wr_bank;
      wr_bank_n    = third_bank(wr_bank, rd_bank);
    end

    // Displayed bank and ready bank trade places; a line finishing in the same
    // cycle is consumed straight away and the old ready bank becomes writable.
    if (swap) begin
      rd_bank_n    = ready_bank_n;
      ready_bank_n = rd_bank;
    end

    rd_valid_n = line_start ? ready_valid_n : rd_valid;

    if (line_start) begin
      fresh_n = 1'b0;
    end else if (wr_line_done) begin
      fresh_n = 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_we[b] = wr_en && wr_in_range && (wr_bank == bank_t'(b));

    line_bank_ram #(
      .DATA_W      (DATA_W),
      .LINE_PIXELS (LINE_PIXELS),
      .AW          (AW)
    ) u_ram (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (wr_xpos),
      .wdata (wr_data),
      .raddr (sx[AW-1:0]),
      .rdata (bank_rdata[b])
    );
  end

  always_comb begin
    pix = bank_rdata[2];
    case (rd_bank_n)
      2'd0:    pix = bank_rdata[0];
      2'd1:    pix = bank_rdata[1];
      default: pix = bank_rdata[2];
    endcase
  end

  assign rd_data_n = (rd_display_on && rd_valid_n && sx_in_range) ? pix : BLANK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= 2'd0;
      ready_bank  <= 2'd1;
      rd_bank     <= 2'd2;
      ready_valid <= 1'b0;
      rd_valid    <= 1'b0;
      fresh       <= 1'b0;
      rd_data     <= BLANK;
      line_missed <= 1'b0;
    end else begin
      wr_bank     <= wr_bank_n;
      ready_bank  <= ready_bank_n;
      rd_bank     <= rd_bank_n;
      ready_valid <= ready_valid_n;
      rd_valid    <= rd_valid_n;
      fresh       <= fresh_n;
      rd_data     <= rd_data_n;
      line_missed <= wr_line_done & fresh;
    end
  end

  a_banks_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    (wr_bank != ready_bank) && (wr_bank != rd_bank) && (ready_bank != rd_bank) &&
    (wr_bank != 2'd3) && (ready_bank != 2'd3) && (rd_bank != 2'd3));

endmodule

// File: tb/tb_scanline_triple_buffer.sv
// Randomised bench for scanline_triple_buffer against a line-copy reference model.
module tb_scanline_triple_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_xpos;
  logic [6:0] wr_data;
  logic       wr_line_done;
  logic [9:0] rd_hpos;
  logic       rd_display_on;
  logic [6:0] rd_data;
  logic       line_missed;

  scanline_triple_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_xpos       (wr_xpos),
    .wr_data       (wr_data),
    .wr_line_done  (wr_line_done),
    .rd_hpos       (rd_hpos),
    .rd_display_on (rd_display_on),
    .rd_data       (rd_data),
    .line_missed   (line_missed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int hpos_cnt = 0;
  int miss_cnt = 0;
  bit disp_rand = 0;

  // Reference: whole-line copies, no notion of banks.
  logic [6:0] m_cur   [160];
  logic [6:0] m_ready [160];
  logic [6:0] m_disp  [160];
  bit         m_fresh = 0;
  bit         m_valid = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t hpos=%0d)", tag, got, exp, $time, hpos_cnt);
    end
  endtask

  // Inputs for this cycle are already driven; advance the model, clock, check.
  task automatic tick();
    logic [6:0] exp_rd;
    bit         exp_ms;
    int         sx;
    exp_rd = 7'd0;
    exp_ms = 1'b0;
    if (!rst_n) begin
      m_fresh = 0;
      m_valid = 0;
    end else begin
      exp_ms = wr_line_done && m_fresh;
      if (wr_en && wr_xpos < 8'd160) m_cur[wr_xpos] = wr_data;
      if (wr_line_done) begin
        m_ready = m_cur;
        m_fresh = 1;
      end
      if (rd_hpos == 10'd0 && m_fresh) begin
        m_disp  = m_ready;
        m_valid = 1;
        m_fresh = 0;
      end
      sx = int'(rd_hpos) / 4;
      if (rd_display_on && m_valid && sx < 160) exp_rd = m_disp[sx];
    end
    @(posedge clk);
    #1;
    chk("rd_data", 32'(rd_data), 32'(exp_rd));
    chk("line_missed", 32'(line_missed), 32'(exp_ms));
    if (line_missed === 1'b1) miss_cnt++;
    hpos_cnt      = (hpos_cnt + 1) % 800;
    rd_hpos       = 10'(hpos_cnt);
    rd_display_on = (hpos_cnt < 720) ^ (disp_rand && $urandom_range(0, 15) == 0);
    wr_en         = 1'b0;
    wr_line_done  = 1'b0;
    wr_xpos       = 8'($urandom);
    wr_data       = 7'($urandom);
  endtask

  // mode 0: random data, 1: data = x[6:0], 2: constant val.
  // done_mode 0: no done, 1: done with last pixel, 2: done one cycle after.
  task automatic write_line(input int mode, input logic [6:0] val, input int n_px,
                            input int gap_max, input int done_mode);
    for (int x = 0; x < n_px; x++) begin
      wr_en   = 1'b1;
      wr_xpos = 8'(x);
      case (mode)
        0:       wr_data = 7'($urandom);
        1:       wr_data = 7'(x);
        default: wr_data = val;
      endcase
      if (x == n_px - 1 && done_mode == 1) wr_line_done = 1'b1;
      tick();
      repeat ($urandom_range(0, gap_max)) begin
        if ($urandom_range(0, 3) == 0) begin
          wr_en   = 1'b1;
          wr_xpos = 8'($urandom_range(160, 255));
          wr_data = 7'($urandom);
        end
        tick();
      end
    end
    if (done_mode == 2) begin
      wr_line_done = 1'b1;
      tick();
    end
  endtask

  task automatic wait_hpos(input int h);
    for (int i = 0; i < 800 && rd_hpos != 10'(h); i++) tick();
  endtask

  initial begin
    rst_n         = 1'b1;
    wr_en         = 1'b0;
    wr_xpos       = 8'd0;
    wr_data       = 7'd0;
    wr_line_done  = 1'b0;
    rd_hpos       = 10'd0;
    rd_display_on = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_line_missed", 32'(line_missed), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Scan with nothing written: blank everywhere, no misses.
    miss_cnt = 0;
    repeat (800) tick();
    chk("idle_miss_cnt", 32'(miss_cnt), 32'd0);

    // Basic fill with index pattern and fixed-position spot checks.
    write_line(1, 7'd0, 160, 2, 2);
    wait_hpos(0);
    for (int i = 0; i < 645; i++) begin
      int h;
      h = hpos_cnt;
      tick();
      if (h == 3)   chk("fill_h3", 32'(rd_data), 32'd0);
      if (h == 4)   chk("fill_h4", 32'(rd_data), 32'd1);
      if (h == 7)   chk("fill_h7", 32'(rd_data), 32'd1);
      if (h == 636) chk("fill_h636", 32'(rd_data), 32'h1F);
      if (h == 640) chk("fill_h640", 32'(rd_data), 32'd0);
    end

    // No tear: line B completes mid-scan while line A is on screen.
    write_line(2, 7'h11, 160, 0, 2);
    wait_hpos(1);
    write_line(2, 7'h22, 160, 1, 2);
    wait_hpos(0);
    repeat (10) tick();
    chk("notear_next_line", 32'(rd_data), 32'h22);

    // Two completed lines with no line start between them.
    wait_hpos(1);
    miss_cnt = 0;
    write_line(2, 7'h44, 160, 0, 2);
    write_line(2, 7'h55, 160, 0, 2);
    wait_hpos(0);
    repeat (20) tick();
    chk("missed_cnt", 32'(miss_cnt), 32'd1);
    chk("missed_shows_second", 32'(rd_data), 32'h55);

    // Line finishes exactly at a line start, last pixel in the same cycle.
    wait_hpos(1);
    write_line(1, 7'd0, 159, 0, 0);
    wait_hpos(0);
    wr_en        = 1'b1;
    wr_xpos      = 8'd159;
    wr_data      = 7'h7F;
    wr_line_done = 1'b1;
    tick();
    for (int i = 0; i < 700; i++) begin
      int h;
      h = hpos_cnt;
      tick();
      if (h == 636) chk("simul_px159", 32'(rd_data), 32'h7F);
    end
    miss_cnt = 0;
    write_line(0, 7'd0, 160, 0, 2);
    chk("simul_no_miss", 32'(miss_cnt), 32'd0);

    // Reset in the middle of a displayed line.
    write_line(2, 7'h33, 160, 0, 2);
    wait_hpos(0);
    tick();
    wait_hpos(100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_data", 32'(rd_data), 32'd0);
    chk("rst_async_missed", 32'(line_missed), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (900) tick();
    write_line(0, 7'd0, 160, 1, 1);
    repeat (900) tick();

    // Randomised producer speed, done placement and display window.
    disp_rand = 1;
    for (int l = 0; l < 14; l++) begin
      int g;
      g = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 1) ? 1 : 8);
      write_line(0, 7'd0, 160, g, $urandom_range(1, 2));
      repeat ($urandom_range(0, 300)) tick();
    end
    repeat (800) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
